// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate sensor path.
package parking_pkg;

  // Direction state machine states for the entry/exit lane.
  typedef enum logic [3:0] {
    ST_WAIT_CLEAR = 4'd0,
    ST_IDLE       = 4'd1,
    ST_IN_A       = 4'd2,
    ST_IN_AB      = 4'd3,
    ST_IN_B       = 4'd4,
    ST_OUT_B      = 4'd5,
    ST_OUT_AB     = 4'd6,
    ST_OUT_A      = 4'd7,
    ST_FAULT      = 4'd8
  } gate_state_t;

  // Beam sensor levels.
  localparam logic BLOCKED = 1'b1;
  localparam logic CLEAR   = 1'b0;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one beam.
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous beam into the clock domain; resets as blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= BLOCKED;
      sync_2 <= BLOCKED;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= BLOCKED;
      cnt   <= '0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync_2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_sensor_decoder.sv
// Turns the two lane beams into clean car_in / car_out pulses and flags bad passages.
module gate_sensor_decoder
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic car_in,
  output logic car_out,
  output logic error,
  output logic busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] AB_NONE = {CLEAR, CLEAR};
  localparam logic [1:0] AB_A    = {BLOCKED, CLEAR};
  localparam logic [1:0] AB_B    = {CLEAR, BLOCKED};
  localparam logic [1:0] AB_BOTH = {BLOCKED, BLOCKED};

  logic          da;
  logic          db;
  logic [1:0]    ab;
  gate_state_t   state;
  gate_state_t   state_nxt;
  logic [TW-1:0] timer;
  logic          in_passage;
  logic          timed_out;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (sensor_a),
    .level (da)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (sensor_b),
    .level (db)
  );

  assign ab = {da, db};

  // Passage states are the only ones under the stuck-car timer.
  always_comb begin
    in_passage = state inside {ST_IN_A, ST_IN_AB, ST_IN_B, ST_OUT_B, ST_OUT_AB, ST_OUT_A};
    timed_out  = in_passage && (timer == TIMER_LAST);
  end

  // Next-state table; a timeout overrides whatever the beams say this cycle.
  always_comb begin
    state_nxt = state;
    if (timed_out) begin
      state_nxt = ST_FAULT;
    end else begin
      case (state)
        ST_WAIT_CLEAR, ST_FAULT: if (ab == AB_NONE) state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (ab == AB_A)         state_nxt = ST_IN_A;
          else if (ab == AB_B)    state_nxt = ST_OUT_B;
          else if (ab == AB_BOTH) state_nxt = ST_FAULT;
        end
        ST_IN_A: begin
          if (ab == AB_BOTH)      state_nxt = ST_IN_AB;
          else if (ab == AB_NONE) state_nxt = ST_IDLE;
          else if (ab == AB_B)    state_nxt = ST_FAULT;
        end
        ST_IN_AB: begin
          if (ab == AB_B)         state_nxt = ST_IN_B;
          else if (ab == AB_A)    state_nxt = ST_IN_A;
          else if (ab == AB_NONE) state_nxt = ST_FAULT;
        end
        ST_IN_B: begin
          if (ab == AB_NONE)      state_nxt = ST_IDLE;
          else if (ab == AB_BOTH) state_nxt = ST_IN_AB;
          else if (ab == AB_A)    state_nxt = ST_FAULT;
        end
        ST_OUT_B: begin
          if (ab == AB_BOTH)      state_nxt = ST_OUT_AB;
          else if (ab == AB_NONE) state_nxt = ST_IDLE;
          else if (ab == AB_A)    state_nxt = ST_FAULT;
        end
        ST_OUT_AB: begin
          if (ab == AB_A)         state_nxt = ST_OUT_A;
          else if (ab == AB_B)    state_nxt = ST_OUT_B;
          else if (ab == AB_NONE) state_nxt = ST_FAULT;
        end
        ST_OUT_A: begin
          if (ab == AB_NONE)      state_nxt = ST_IDLE;
          else if (ab == AB_BOTH) state_nxt = ST_OUT_AB;
          else if (ab == AB_B)    state_nxt = ST_FAULT;
        end
        default: state_nxt = ST_WAIT_CLEAR;
      endcase
    end
  end

  // State register; a car present at reset release is absorbed by WAIT_CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_WAIT_CLEAR;
    else       state <= state_nxt;
  end

  // Per-state dwell timer, restarted on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (!in_passage || (state_nxt != state)) begin
      timer <= '0;
    end else if (timer != TIMER_LAST) begin
      timer <= timer + 1'b1;
    end
  end

  // Registered outputs, aligned with the state change that causes them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car_in  <= 1'b0;
      car_out <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      car_in  <= (state == ST_IN_B)  && (state_nxt == ST_IDLE);
      car_out <= (state == ST_OUT_A) && (state_nxt == ST_IDLE);
      error   <= (state_nxt == ST_FAULT) && (state != ST_FAULT);
      busy    <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed plus randomized bench for gate_sensor_decoder with a passage-level reference model.
module tb_gate_sensor_decoder;

  localparam int DEB = 4;
  localparam int TMO = 1000;

  logic clk = 1'b0;
  logic reset;
  logic sensor_a;
  logic sensor_b;
  logic car_in;
  logic car_out;
  logic error;
  logic busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_in = 0, n_out = 0, n_err = 0;
  int last_in = -1, last_out = -1, last_err = -1;

  gate_sensor_decoder #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .car_in   (car_in),
    .car_out  (car_out),
    .error    (error),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model: a passage is a walk along a 4-point track (clear, first beam,
  // both beams, second beam, clear); stepping forward past the end counts a car,
  // stepping back to the start is an abort, anything else is a fault.
  typedef enum int {M_WAIT, M_IDLE, M_PASS, M_FAULT} mode_t;

  typedef struct {
    logic [DEB+1:0] ha;
    logic [DEB+1:0] hb;
    logic           da;
    logic           db;
    mode_t          mode;
    logic           entry;
    int             step;
    int             dwell;
    logic           car_in;
    logic           car_out;
    logic           error;
    logic           busy;
  } model_t;

  model_t m;

  function automatic logic [1:0] pat(input logic entry, input int step);
    logic [1:0] p;
    case (step)
      1: p = 2'b10;
      2: p = 2'b11;
      3: p = 2'b01;
      default: p = 2'b00;
    endcase
    if (!entry) p = {p[0], p[1]};
    return p;
  endfunction

  // History bit 0 is the sample taken at this edge; bits 2..DEB+1 are the samples
  // that have made it through the synchroniser, all of which must disagree to flip.
  function automatic logic deb_level(input logic [DEB+1:0] h, input logic lvl);
    logic [DEB-1:0] win;
    win = h[DEB+1:2];
    return (win == {DEB{~lvl}}) ? ~lvl : lvl;
  endfunction

  function automatic model_t model_step(input model_t c, input logic ra, input logic rb, input logic rst);
    model_t n;
    logic [1:0] in;
    n = c;
    if (rst) begin
      n.ha = '1; n.hb = '1; n.da = 1'b1; n.db = 1'b1;
      n.mode = M_WAIT; n.entry = 1'b0; n.step = 0; n.dwell = 0;
      n.car_in = 1'b0; n.car_out = 1'b0; n.error = 1'b0; n.busy = 1'b1;
      return n;
    end
    n.ha = {c.ha[DEB:0], ra};
    n.hb = {c.hb[DEB:0], rb};
    n.da = deb_level(n.ha, c.da);
    n.db = deb_level(n.hb, c.db);
    in = {c.da, c.db};
    n.car_in = 1'b0; n.car_out = 1'b0; n.error = 1'b0; n.dwell = 0;
    case (c.mode)
      M_WAIT, M_FAULT: if (in == 2'b00) n.mode = M_IDLE;
      M_IDLE: begin
        if (in == 2'b11) begin
          n.mode = M_FAULT; n.error = 1'b1;
        end else if (in != 2'b00) begin
          n.mode = M_PASS; n.entry = (in == 2'b10); n.step = 1;
        end
      end
      M_PASS: begin
        if (c.dwell + 1 >= TMO) begin
          n.mode = M_FAULT; n.error = 1'b1;
        end else if (in == pat(c.entry, c.step + 1)) begin
          if (c.step == 3) begin
            n.mode = M_IDLE; n.car_in = c.entry; n.car_out = !c.entry;
          end else n.step = c.step + 1;
        end else if (in == pat(c.entry, c.step - 1)) begin
          if (c.step == 1) n.mode = M_IDLE;
          else n.step = c.step - 1;
        end else if (in != pat(c.entry, c.step)) begin
          n.mode = M_FAULT; n.error = 1'b1;
        end else begin
          n.dwell = c.dwell + 1;
        end
      end
      default: n.mode = M_WAIT;
    endcase
    n.busy = (n.mode != M_IDLE);
    return n;
  endfunction

  always @(posedge clk) m <= model_step(m, sensor_a, sensor_b, reset);

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    chk("car_in", car_in, m.car_in);
    chk("car_out", car_out, m.car_out);
    chk("error", error, m.error);
    chk("busy", busy, m.busy);
    if (car_in)  begin n_in++;  last_in  = cyc; end
    if (car_out) begin n_out++; last_out = cyc; end
    if (error)   begin n_err++; last_err = cyc; end
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) tick();
  endtask

  task automatic clear_counts();
    n_in = 0; n_out = 0; n_err = 0;
    last_in = -1; last_out = -1; last_err = -1;
  endtask

  int edge0;
  int k;

  initial begin
    reset = 1'b1; sensor_a = 1'b0; sensor_b = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 1'b1);
    chk("reset_car_in", car_in, 1'b0);

    // Release with lane clear: busy until edge 3+DEB.
    reset = 1'b0;
    cyc = 0;
    clear_counts();
    repeat (2 + DEB) tick();
    chk("busy_before_idle", busy, 1'b1);
    tick();
    chk("busy_idle", busy, 1'b0);
    chk_int("startup_pulses", n_in + n_out + n_err, 0);

    // Clean entry, 10 cycles per phase.
    clear_counts();
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    edge0 = cyc + 1;
    hold(0, 0, 15);
    chk_int("entry_count", n_in, 1);
    chk_int("entry_no_out", n_out, 0);
    chk_int("entry_latency", last_in - edge0, 2 + DEB);

    // Clean exit.
    clear_counts();
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 15);
    chk_int("exit_count", n_out, 1);
    chk_int("exit_no_in", n_in, 0);

    // Entry with short glitches on sensor_a in every phase.
    clear_counts();
    hold(1, 0, 4); hold(0, 0, 2); hold(1, 0, 6);
    hold(1, 1, 4); hold(0, 1, 2); hold(1, 1, 6);
    hold(0, 1, 4); hold(1, 1, 2); hold(0, 1, 6);
    hold(0, 0, 15);
    chk_int("glitch_entry_count", n_in, 1);
    chk_int("glitch_entry_err", n_err + n_out, 0);

    // Aborted passages.
    clear_counts();
    hold(1, 0, 10); hold(0, 0, 15);
    chk_int("abort_a_pulses", n_in + n_out + n_err, 0);
    chk("abort_a_idle", busy, 1'b0);
    hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 15);
    chk_int("abort_ab_pulses", n_in + n_out + n_err, 0);
    chk("abort_ab_idle", busy, 1'b0);

    // Stuck in IN_A until the timer expires.
    clear_counts();
    edge0 = cyc + 1;
    hold(1, 0, 1100);
    chk_int("timeout_err_count", n_err, 1);
    chk_int("timeout_latency", last_err - edge0, 2 + DEB + TMO);
    chk("timeout_fault_busy", busy, 1'b1);
    hold(0, 0, 15);
    chk("timeout_recover_idle", busy, 1'b0);

    // Both beams at once from IDLE.
    clear_counts();
    hold(1, 1, 10);
    chk_int("simul_err", n_err, 1);
    hold(0, 0, 15);
    chk("simul_recover_idle", busy, 1'b0);

    // Reset in IN_AB, released with the car still in the lane.
    clear_counts();
    hold(1, 0, 10); hold(1, 1, 10);
    reset = 1'b1;
    hold(1, 1, 2);
    reset = 1'b0;
    hold(1, 1, 20); hold(0, 0, 15);
    chk_int("reset_mid_in", n_in + n_out, 0);
    chk_int("reset_mid_err", n_err, 0);
    chk("reset_mid_idle", busy, 1'b0);

    // Randomized passages, checked cycle by cycle against the model.
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 3);
      if (k == 0) begin
        hold(1, 0, $urandom_range(3, 14)); hold(1, 1, $urandom_range(3, 14));
        hold(0, 1, $urandom_range(3, 14));
      end else if (k == 1) begin
        hold(0, 1, $urandom_range(3, 14)); hold(1, 1, $urandom_range(3, 14));
        hold(1, 0, $urandom_range(3, 14));
      end else begin
        for (int j = 0; j < 4; j++)
          hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
      end
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      hold(0, 0, $urandom_range(8, 14));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sensor_decoder.md
# gate_sensor_decoder

Upstream stage of the car-parking counter: converts two raw beam-break sensors at the single entry/exit lane into clean one-cycle `car_in` / `car_out` pulses for the occupancy counter.
- Synchronises and debounces both sensors, then runs a direction state machine.
- Rejects aborted, reversed, stuck and out-of-order passages; flags these with an error pulse.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples before a debounced level changes; legal range ≥1.
- `TIMEOUT_CYCLES`, default 1000: maximum cycles the FSM may stay in one passage state; legal range ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `sensor_a` in 1: outer beam, raw and asynchronous; 1 = blocked.
- `sensor_b` in 1: inner beam, raw and asynchronous; 1 = blocked.
- `car_in` out 1: one-cycle pulse per completed entry (A→AB→B→clear).
- `car_out` out 1: one-cycle pulse per completed exit (B→AB→A→clear).
- `error` out 1: one-cycle pulse on entry to FAULT.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Per sensor: 2-flop synchroniser, then debouncer.
  - Debounced level `da`/`db` takes the synchronised value only after it differs from the current level for DEBOUNCE_CYCLES consecutive cycles.
  - Any sample equal to the current level clears the counter.
- States: WAIT_CLEAR, IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A, FAULT. Inputs are written (da,db).
- IDLE:
  - 10→IN_A
  - 01→OUT_B
  - 11→FAULT
  - 00 stay
- IN_A:
  - 11→IN_AB
  - 00→IDLE (abort, no pulse)
  - 01→FAULT
- IN_AB:
  - 01→IN_B
  - 10→IN_A (backing out)
  - 00→FAULT
- IN_B:
  - 00→IDLE with `car_in`
  - 11→IN_AB
  - 10→FAULT
- OUT_B, OUT_AB, OUT_A mirror IN_A, IN_AB, IN_B with a and b swapped; OUT_A 00→IDLE with `car_out`.
- FAULT: stay until 00, then →IDLE.
- WAIT_CLEAR: same exit rule as FAULT, but entry produces no `error`.
- Unlisted input combinations hold state.
- Timeout:
  - A per-state timer clears on every state change and counts while in IN_* / OUT_*.
  - On reaching TIMEOUT_CYCLES without a transition → FAULT with `error`.
  - Timeout takes priority over a same-cycle table transition.
- Pulses, `error` and `busy` are registered. `car_in` and `car_out` are mutually exclusive and never adjacent-cycle repeated.

## Timing
- Reset values:
  - Synchroniser flops and `da`/`db` = 1 (blocked).
  - State = WAIT_CLEAR, `busy` = 1.
  - `car_in`, `car_out`, `error` = 0; all counters 0.
- After reset release with both sensors clear:
  - `da`/`db` fall at edge 2+DEBOUNCE_CYCLES.
  - IDLE and `busy`=0 at the following edge.
- Latency: a raw sensor change first sampled at edge N changes `da`/`db` at edge N+1+DEBOUNCE_CYCLES. State changes and pulses follow at edge N+2+DEBOUNCE_CYCLES.
  - Default: `car_in` rises 6 cycles after the last beam clears.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no effect on `da`/`db`.
- Both debounced levels changing on the same edge: evaluated as one combined input per the table (e.g. IDLE 00→11 = FAULT).
- Reset mid-passage: no pulse emitted. A car still in the lane at release is absorbed by WAIT_CLEAR and not counted.
- Counter widths: `$clog2(DEBOUNCE_CYCLES+1)` and `$clog2(TIMEOUT_CYCLES+1)`; no wrap, saturate at threshold.

## Structure
- Shared package `parking_pkg`: `gate_state_t` enum (9 states, 4-bit encoding), sensor-level constants BLOCKED=1 / CLEAR=0.
- Sub-module `sensor_debounce`: synchroniser plus debouncer, parameter DEBOUNCE_CYCLES, ports `clk`, `reset`, `raw`, `level`; reset level 1.
  - Instantiated twice.
  - FSM, timer and output registers live in the top.

## Test plan
- Reset held, sensors 00, release → `busy` 1 until edge 3+DEBOUNCE_CYCLES, then 0; no pulses, no `error`.
- Entry sequence, each raw phase held 10 cycles: 00→10→11→01→00 → exactly one `car_in`, 6 cycles after final clear; `car_out` 0.
- Exit sequence 00→01→11→10→00 → exactly one `car_out`; then entry with `sensor_a` glitching 2-cycle pulses mid-phase → one `car_in` only.
- Aborts:
  - 00→10→00 → no pulse, IDLE.
  - 00→10→11→10→00 → no pulse.
- Faults:
  - `sensor_a` held blocked 1100 cycles in IN_A → `error` at 1000 cycles in state; stays FAULT until clear, then IDLE.
  - 00→11 simultaneous → `error`.
- Reset asserted in IN_AB with sensors 11, released with sensors still 11, then cleared → no `car_in`, no `error`; IDLE after debounce.
